// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the register-file write path.
// Word, register select and buffered write-request bundle.
package cpu_types_pkg;

  localparam int NREQ   = 2;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } rf_wreq_t;

  // r0 is hardwired, so a pending write to it is never a hazard
  function automatic logic rd_hit(
    input logic     full,
    input rf_wreq_t e,
    input regbits_t rsel
  );
    return full & (e.sel == rsel) & (e.sel != '0);
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bundle: two valid/ready ports with
// destination select and data each.
interface rf_write_arbiter_if
  import cpu_types_pkg::*;
;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  regbits_t        req_sel0;
  regbits_t        req_sel1;
  word_t           req_dat0;
  word_t           req_dat1;

  modport master (
    output req_valid,
    output req_sel0,
    output req_sel1,
    output req_dat0,
    output req_dat1,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel0,
    input  req_sel1,
    input  req_dat0,
    input  req_dat1,
    output req_ready
  );
endinterface

// File: rtl/rf_write_arbiter_buffer.sv
// One-entry write holding buffer with read-select hazard
// compares. Load has priority over clear (refill when granted).
module rf_wr_buffer
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     load,
  input  logic     clr,
  input  rf_wreq_t din,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output logic     full,
  output rf_wreq_t q,
  output logic     hz1,
  output logic     hz2
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= din;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

  assign hz1 = rd_hit(full, q, rsel1);
  assign hz2 = rd_hit(full, q, rsel2);

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: two buffered writeback
// sources, oldest-first grant with round-robin tie-break.
module rf_write_arbiter
  import cpu_types_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  rf_write_arbiter_if.slave   rif,
  input  regbits_t            rsel1,
  input  regbits_t            rsel2,
  output logic                hazard1,
  output logic                hazard2,
  output logic                WEN,
  output regbits_t            wsel,
  output word_t               wdat,
  output logic [NREQ-1:0]     gnt
);

  logic     full0, full1;
  rf_wreq_t q0, q1, wq;
  logic     h01, h02, h11, h12;
  logic     load0, load1;
  logic     stay1;
  logic     tie_q, old1_q, rr_q;
  logic     pick1;

  assign rif.req_ready = {~full1 | gnt[1], ~full0 | gnt[0]};
  assign load0 = rif.req_valid[0] & rif.req_ready[0];
  assign load1 = rif.req_valid[1] & rif.req_ready[1];
  assign stay1 = full1 & ~gnt[1];

  rf_wr_buffer u_buf0 (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (load0),
    .clr   (gnt[0]),
    .din   ('{sel: rif.req_sel0, dat: rif.req_dat0}),
    .rsel1 (rsel1),
    .rsel2 (rsel2),
    .full  (full0),
    .q     (q0),
    .hz1   (h01),
    .hz2   (h02)
  );

  rf_wr_buffer u_buf1 (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (load1),
    .clr   (gnt[1]),
    .din   ('{sel: rif.req_sel1, dat: rif.req_dat1}),
    .rsel1 (rsel1),
    .rsel2 (rsel2),
    .full  (full1),
    .q     (q1),
    .hz1   (h11),
    .hz2   (h12)
  );

  assign pick1 = tie_q ? rr_q : old1_q;

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      full0 & full1:  gnt = pick1 ? 2'b10 : 2'b01;
      full0 & ~full1: gnt = 2'b01;
      ~full0 & full1: gnt = 2'b10;
      default:        gnt = '0;
    endcase
  end

  always_comb begin
    wq = '0;
    unique case (1'b1)
      gnt[0]:  wq = q0;
      gnt[1]:  wq = q1;
      default: wq = '0;
    endcase
  end

  assign wsel    = wq.sel;
  assign wdat    = wq.dat;
  assign WEN     = (|gnt) & (wq.sel != '0);
  assign hazard1 = h01 | h11;
  assign hazard2 = h02 | h12;

  // Same-register simultaneous arrivals are forced to non-tie,
  // port 0 older, so the load result lands last.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tie_q  <= 1'b0;
      old1_q <= 1'b0;
      rr_q   <= 1'b0;
    end else begin
      if (full0 & full1 & tie_q)
        rr_q <= ~rr_q;
      if (load0 & load1) begin
        tie_q  <= (rif.req_sel0 != rif.req_sel1);
        old1_q <= 1'b0;
      end else if (load0) begin
        tie_q  <= 1'b0;
        old1_q <= stay1;
      end else if (load1) begin
        tie_q  <= 1'b0;
        old1_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, age
// order, tie streaming, same-register order, r0 and mid-op reset.
module tb_rf_write_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  regbits_t    rsel1, rsel2;
  logic        hazard1, hazard2, WEN;
  regbits_t    wsel;
  word_t       wdat;
  logic [1:0]  gnt;

  int ntest;
  int nfail;
  int n0, n1;
  int iss0, iss1, b0, b1;
  word_t rf [32] = '{default: '0};

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .rif     (bus),
    .rsel1   (rsel1),
    .rsel2   (rsel2),
    .hazard1 (hazard1),
    .hazard2 (hazard2),
    .WEN     (WEN),
    .wsel    (wsel),
    .wdat    (wdat),
    .gnt     (gnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WEN) rf[wsel] <= wdat;
    if (gnt[0]) n0 <= n0 + 1;
    if (gnt[1]) n1 <= n1 + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    ntest = 0; nfail = 0; n0 = 0; n1 = 0;
    nRST = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_sel0 = 5'd4; bus.req_dat0 = 32'h1;
    bus.req_sel1 = 5'd6; bus.req_dat1 = 32'h2;
    rsel1 = 5'd4; rsel2 = 5'd6;
    #1 nRST = 1'b0;
    #12;
    chk("rst_wen", 64'(WEN), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'b11);
    chk("rst_hz", 64'({hazard1, hazard2}), 64'd0);

    step(); nRST = 1'b1; bus.req_valid = 2'b00;
    #1 chk("post_rst_wen", 64'(WEN), 64'd0);
    step(); #1 chk("idle_gnt", 64'(gnt), 64'd0);

    // single write
    bus.req_valid = 2'b01; bus.req_sel0 = 5'd5;
    bus.req_dat0 = 32'hDEADBEEF; rsel1 = 5'd5; rsel2 = 5'd6;
    #1 chk("sw_hz_pre", 64'(hazard1), 64'd0);
    step(); bus.req_valid = 2'b00; #1;
    chk("sw_wen", 64'(WEN), 64'd1);
    chk("sw_wsel", 64'(wsel), 64'd5);
    chk("sw_wdat", 64'(wdat), 64'hDEADBEEF);
    chk("sw_gnt", 64'(gnt), 64'b01);
    chk("sw_hz", 64'({hazard1, hazard2}), 64'b10);
    step(); #1;
    chk("sw_clr_gnt", 64'(gnt), 64'd0);
    chk("sw_clr_hz", 64'(hazard1), 64'd0);
    chk("sw_rf5", 64'(rf[5]), 64'hDEADBEEF);

    // age order
    bus.req_valid = 2'b10; bus.req_sel1 = 5'd3;
    bus.req_dat1 = 32'h11; rsel1 = 5'd3;
    step(); bus.req_valid = 2'b01; bus.req_sel0 = 5'd3;
    bus.req_dat0 = 32'h22; #1;
    chk("age_gnt1", 64'(gnt), 64'b10);
    chk("age_wdat1", 64'(wdat), 64'h11);
    step(); bus.req_valid = 2'b00; #1;
    chk("age_gnt2", 64'(gnt), 64'b01);
    chk("age_wdat2", 64'(wdat), 64'h22);
    chk("age_hz", 64'(hazard1), 64'd1);
    step(); #1;
    chk("age_rf3", 64'(rf[3]), 64'h22);
    chk("age_idle", 64'(gnt), 64'd0);

    // tie streaming
    b0 = n0; b1 = n1; iss0 = 0; iss1 = 0;
    for (int c = 0; c < 100; c++) begin
      bus.req_valid = 2'b11;
      bus.req_sel0 = regbits_t'(8 + (iss0 % 8));
      bus.req_dat0 = 32'h1000_0000 + iss0;
      bus.req_sel1 = regbits_t'(16 + (iss1 % 8));
      bus.req_dat1 = 32'h2000_0000 + iss1;
      #1;
      if (c == 0) chk("st_gnt0", 64'(gnt), 64'd0);
      else begin
        chk("st_gnt", 64'(gnt), (c % 2 == 1) ? 64'b01 : 64'b10);
        chk("st_ready", 64'(bus.req_ready), 64'(gnt));
        chk("st_wdat", 64'(wdat), gnt[0] ?
            64'(32'h1000_0000 + (n0 - b0)) :
            64'(32'h2000_0000 + (n1 - b1)));
      end
      if (bus.req_ready[0]) iss0++;
      if (bus.req_ready[1]) iss1++;
      step();
    end
    bus.req_valid = 2'b00;
    step(); step(); #1;
    chk("st_drain", 64'(gnt), 64'd0);
    chk("st_cnt0", 64'(n0 - b0), 64'(iss0));
    chk("st_cnt1", 64'(n1 - b1), 64'(iss1));

    // rr now 1: distinct-sel tie grants port 1 first
    bus.req_valid = 2'b11; bus.req_sel0 = 5'd9;
    bus.req_sel1 = 5'd10; bus.req_dat0 = 32'hA9;
    bus.req_dat1 = 32'hB10;
    step(); bus.req_valid = 2'b00; #1;
    chk("rr_gnt1", 64'(gnt), 64'b10);
    step(); #1 chk("rr_gnt2", 64'(gnt), 64'b01);
    step();

    // same register same edge: port 0 first regardless of rr
    bus.req_valid = 2'b11; bus.req_sel0 = 5'd7;
    bus.req_sel1 = 5'd7; bus.req_dat0 = 32'hAAAA0000;
    bus.req_dat1 = 32'hBBBB0000;
    step(); bus.req_valid = 2'b00; #1;
    chk("same_gnt1", 64'(gnt), 64'b01);
    chk("same_wdat1", 64'(wdat), 64'hAAAA0000);
    step(); #1 chk("same_gnt2", 64'(gnt), 64'b10);
    step(); #1 chk("same_rf7", 64'(rf[7]), 64'hBBBB0000);

    // r0 write
    bus.req_valid = 2'b01; bus.req_sel0 = 5'd0;
    bus.req_dat0 = 32'hFFFFFFFF; rsel1 = 5'd0; rsel2 = 5'd0;
    step(); bus.req_valid = 2'b00; #1;
    chk("r0_gnt", 64'(gnt), 64'b01);
    chk("r0_wen", 64'(WEN), 64'd0);
    chk("r0_hz", 64'({hazard1, hazard2}), 64'd0);
    chk("r0_ready", 64'(bus.req_ready[0]), 64'd1);
    step(); #1;
    chk("r0_done", 64'(gnt), 64'd0);
    chk("r0_rf0", 64'(rf[0]), 64'd0);

    // mid-operation reset
    bus.req_valid = 2'b11; bus.req_sel0 = 5'd12;
    bus.req_sel1 = 5'd13; bus.req_dat0 = 32'hC;
    bus.req_dat1 = 32'hD; rsel1 = 5'd12; rsel2 = 5'd13;
    step(); bus.req_valid = 2'b00; #1;
    chk("mr_wen_pre", 64'(WEN), 64'd1);
    chk("mr_hz_pre", 64'({hazard1, hazard2}), 64'b11);
    #1 nRST = 1'b0; #1;
    chk("mr_wen", 64'(WEN), 64'd0);
    chk("mr_gnt", 64'(gnt), 64'd0);
    chk("mr_ready", 64'(bus.req_ready), 64'b11);
    chk("mr_hz", 64'({hazard1, hazard2}), 64'd0);
    step(); nRST = 1'b1;
    bus.req_valid = 2'b01; bus.req_sel0 = 5'd5;
    bus.req_dat0 = 32'hDEADBEEF; rsel1 = 5'd5;
    step(); bus.req_valid = 2'b00; #1;
    chk("mr_sw_gnt", 64'(gnt), 64'b01);
    chk("mr_sw_wdat", 64'(wdat), 64'hDEADBEEF);
    chk("mr_sw_hz", 64'(hazard1), 64'd1);
    step(); #1 chk("mr_sw_clr", 64'(gnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port between two writeback sources: port 0 (ALU/execute result) and port 1 (load/memory result).
- Each source has a valid/ready handshake and a one-entry holding buffer.
- Buffered entries are granted to the register-file write port oldest-first, with round-robin tie-break.
- Pending-write hazard flags are given for the two read selects so decode can stall.
- Sits between the writeback sources and the register file write inputs (WEN/wsel/wdat).

Parameters:
NREQ, 2, number of write requesters (fixed at 2; not generic)
REG_W, 5, register select width
DATA_W, 32, write data width (word_t)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
req_valid  in  2  requester i presents a write
req_ready  out  2  requester i buffer can accept this cycle
req_sel0, req_sel1  in  5 each  destination register per requester
req_dat0, req_dat1  in  32 each  write data per requester
rsel1, rsel2  in  5 each  decode read selects for hazard lookup
hazard1, hazard2  out  1 each  pending buffered write to rsel1 / rsel2
WEN  out  1  register file write enable
wsel  out  5  register file write select
wdat  out  32  register file write data
gnt  out  2  one-hot; which buffer drives the write port this cycle

Behaviour:
- Reset (async, nRST=0): both buffers empty, age flag cleared, rr pointer = 0.
  - Outputs during reset: WEN=0, wsel=0, wdat=0, gnt=00, hazard1=hazard2=0, req_ready=11.
- Buffer i (full_i, sel_i, dat_i, seq_i):
  - Captures req_sel/req_dat at a rising edge where req_valid[i] & req_ready[i].
  - req_ready[i] = ~full_i | gnt[i]. A granted buffer may be refilled in the same edge.
- Arbitration is combinational over the buffer state:
  - Only buffer i full -> gnt = one-hot i.
  - Both full -> grant the older entry.
    - older_is_1 flag: set when buffer 1 is already full while buffer 0 loads, and vice versa.
    - If both load on the same edge, grant rr; rr toggles after every grant made under the tie rule.
  - Neither full -> gnt=00, WEN=0, wsel=0, wdat=0.
- Write port:
  - wsel/wdat = granted buffer's sel/dat.
  - WEN = |gnt & (wsel != 0). A write to r0 is granted and consumed but never asserts WEN.
- Latency: a write accepted at edge N drives WEN during cycle N..N+1 and is committed at edge N+1 at the earliest. Worst case is edge N+2 (loses to an older entry).
- Ordering: two writes to the same register held simultaneously commit in arrival order. Same-edge arrivals to the same register: port 1 (load) wins last, i.e. port 0 is granted first; rr is overridden in this case only.
- Buffer clear: the granted buffer clears at the next edge unless it is refilled on that edge.
- Throughput: one write per cycle sustained. With both ports streaming, each port gets 1/2 bandwidth.
- Hazards:
  - hazardK = (full0 & sel0==rselK & sel0!=0) | (full1 & sel1==rselK & sel1!=0).
  - Purely combinational from the buffers; incoming unaccepted requests are not included.
- Reset mid-operation: buffered entries are discarded without a write. Requesters must reissue.
- req_valid without ready: the requester holds sel/dat stable until accepted (AXI-style; no drop).

Decomposition:
- cpu_types_pkg: word_t, regbits_t (5-bit). Add a typedef rf_wreq_t {regbits_t sel; word_t dat;} for a buffered write request.
- Sub-module rf_wr_buffer: one-entry buffer with full flag, load/clear, and a hazard compare output. Instantiated twice.
- Age/rr tracking and the write mux stay in the top.

Test Plan:
- Reset state: assert nRST=0 with req_valid=11 -> WEN=0, gnt=00, req_ready=11, hazards 0. Release reset -> no write until the first accept edge.
- Single write: port0 sel=5, dat=0xDEADBEEF accepted at edge N -> cycle after N: WEN=1, wsel=5, wdat=0xDEADBEEF, gnt=01, hazard1=1 when rsel1=5. Buffer clears at edge N+1.
- Age order: port1 (sel=3, 0x11) accepted at edge N; port0 (sel=3, 0x22) accepted at edge N+1 -> commits at N+1 of 0x11, then at N+2 of 0x22. Final r3=0x22.
- Same-edge tie: both valid every cycle with distinct sels -> gnt alternates 01,10,01,10. Each port's req_ready is 1 only when its buffer is granted. No lost writes over 100 cycles.
- r0 write: port0 sel=0, dat=0xFFFFFFFF -> gnt=01, WEN=0, hazard never set for rsel=0. The requester is acked next cycle.
- Mid-operation reset: both buffers full, nRST pulsed low between edges -> WEN drops asynchronously to 0, buffers empty. The first post-reset accept behaves as in the single-write test.
